ysyx_22041752_data_sram_resp: RTL and testbench
===============================================

# ysyx_22041752_data_sram_resp

Responder end of the core's data SRAM interface. It samples the `data_sram_*` request that the EXU drives, serves RAM accesses from an internal word array, and serves two MMIO devices: a buffered serial TX port and a microsecond RTC. Read data is returned one cycle later, which matches the MEU's fixed one-cycle load expectation. It sits beside `top` in the simulation/SoC wrapper and replaces the external data-memory model.

## Interface
Parameters:
- `DATA_WD`, 64: data bus width.
- `ADDR_WD`, 64: address width.
- `WEN_WD`, 8: byte-enable width (`DATA_WD/8`).
- `RAM_BASE`, 64'h8000_0000: RAM region base address.
- `RAM_DEPTH`, 4096: RAM depth in 64-bit words (power of 2).
- `UART_ADDR`, 64'ha000_03f8: serial TX register address.
- `RTC_ADDR`, 64'ha000_0048: RTC register address.
- `TICK_DIV`, 100: clock cycles per RTC microsecond (at least 2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `data_sram_en`  in  1  request strobe.
- `data_sram_wen`  in  WEN_WD  byte write enables. Nonzero means write, zero means read.
- `data_sram_addr`  in  ADDR_WD  byte address. Bits [2:0] are ignored.
- `data_sram_wdata`  in  DATA_WD  write data, lane-aligned.
- `data_sram_rdata`  out  DATA_WD  read data, registered.
- `uart_tx_data`  out  8  FIFO head byte.
- `uart_tx_valid`  out  1  FIFO not empty.
- `uart_tx_ready`  in  1  sink accepts the head byte.
- `uart_ovf_cnt`  out  8  count of dropped TX bytes; saturates at 255.
- `bad_access`  out  1  sticky flag, set on any access to an unmapped address.

## Operation
- Decode uses `data_sram_addr & ~7`:
  - RAM hit when the address is in [RAM_BASE, RAM_BASE+RAM_DEPTH*8).
  - UART hit and RTC hit are exact word matches.
  - Anything else is unmapped.
- RAM write: each byte lane i with `wen[i]=1` is written at the clock edge where `en=1`. Other lanes are preserved.
- RAM read: the full word is registered into `data_sram_rdata`.
- UART write with `wen[0]=1`: `wdata[7:0]` is pushed into an 8-entry FIFO.
  - Writes with `wen[0]=0` are ignored.
  - If the FIFO is full and not popping, the byte is dropped and `uart_ovf_cnt` increments.
- UART read returns `{56'b0, 4'b0, count[3:0]}`.
- FIFO pop: occurs when `uart_tx_valid && uart_tx_ready`.
  - `uart_tx_data` always shows the head byte.
- RTC: a prescaler counts 0..TICK_DIV-1. On wrap, a 64-bit `us` counter increments.
  - RTC read returns `us`.
  - RTC write (any nonzero wen) clears both `us` and the prescaler.
- Unmapped access: a read returns 0, a write is dropped, and `bad_access` is set until reset.
- When `en=0` or on a write, `data_sram_rdata` holds its previous value.

## Timing
- Read latency is exactly 1 cycle: request at edge N, data valid after edge N and held until the next read request.
- Write visibility: a read issued the cycle after a write to the same word returns the new data.
- FIFO push and pop in the same cycle:
  - When full, the push is accepted and the count stays at 8.
  - When the FIFO has 1 entry, the count stays at 1 and the head advances.
- An RTC clear in the same cycle as a prescaler wrap: the clear wins, so `us`=0.
- `us` wraps from 2^64-1 to 0.
- Pointers are 3-bit with wrap-around; count is 4-bit.
- Reset values while `reset`=0 (any cycle, including mid-transfer):
  - `data_sram_rdata`=0, FIFO empty, `uart_tx_valid`=0, `uart_tx_data`=0.
  - `uart_ovf_cnt`=0, `bad_access`=0, `us`=0, prescaler=0.
  - RAM contents are not reset.
- Requests presented while reset is asserted are ignored.

## Configuration
- `YSYX_22041752_RTC_EN` defined: the RTC prescaler and counter exist as described above.
- Not defined: no RTC logic is built, and RTC_ADDR decodes as unmapped. Reads return 0 and set `bad_access`.

## Test plan
- Byte-masked write: write 64'h1122334455667788 with wen 8'hFF to 0x8000_0010, then wen 8'h0F with 64'hAAAAAAAA_BBBBBBBB, then read -> rdata 64'h11223344_BBBBBBBB one cycle after the read request.
- UART overflow: hold `uart_tx_ready`=0 and write bytes 0x41..0x4A (10 writes) -> count 8, `uart_ovf_cnt`=2. Raise ready -> 0x41..0x48 drain in order, one per cycle.
- UART push and pop together: FIFO full, ready=1, push 0x5A -> count stays 8 and 0x5A becomes the last byte out.
- RTC with `TICK_DIV`=4: after 40 cycles a read returns 10. A write on a wrap cycle -> the next read after 3 cycles returns 0.
- Unmapped access: read 0x0000_1000 -> rdata 0 and `bad_access`=1, which persists through subsequent valid accesses.
- Asynchronous reset: assert reset mid-drain with 5 bytes queued -> `uart_tx_valid`=0 immediately, count 0 after release, and RAM data written earlier still reads back intact.

Source files
------------

// File: rtl/ysyx_22041752_data_sram_resp_if.sv
// ysyx_22041752_data_sram_resp_if: data SRAM request/response bus between the EXU and its responder
interface ysyx_22041752_data_sram_resp_if #(
    parameter int DATA_WD = 64,
    parameter int ADDR_WD = 64,
    parameter int WEN_WD  = DATA_WD / 8
);
    logic               en;
    logic [WEN_WD-1:0]  wen;
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] wdata;
    logic [DATA_WD-1:0] rdata;
    modport master (output en, wen, addr, wdata, input rdata);
    modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/ysyx_22041752_data_sram_resp.sv
// ysyx_22041752_data_sram_resp: data SRAM responder with RAM, buffered UART TX and an RTC enabled by YSYX_22041752_RTC_EN
module ysyx_22041752_data_sram_resp #(
    parameter int                 DATA_WD   = 64,
    parameter int                 ADDR_WD   = 64,
    parameter int                 WEN_WD    = 8,
    parameter logic [ADDR_WD-1:0] RAM_BASE  = 'h8000_0000,
    parameter int                 RAM_DEPTH = 4096,
    parameter logic [ADDR_WD-1:0] UART_ADDR = 'ha000_03f8,
    parameter logic [ADDR_WD-1:0] RTC_ADDR  = 'ha000_0048,
    parameter int                 TICK_DIV  = 100
) (
    input  logic                            clk,
    input  logic                            reset,
    ysyx_22041752_data_sram_resp_if.slave   data_sram,
    output logic [7:0]                      uart_tx_data,
    output logic                            uart_tx_valid,
    input  logic                            uart_tx_ready,
    output logic [7:0]                      uart_ovf_cnt,
    output logic                            bad_access
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WD-1:0] RAM_BYTES = ADDR_WD'(RAM_DEPTH) << 3;
    logic [ADDR_WD-1:0] a, ram_off;
    logic [AW-1:0]      idx;
    logic               ram_hit, uart_hit, rtc_hit, wr, rd;
    logic               push_req, push, pop;
    logic [DATA_WD-1:0] mem [RAM_DEPTH];
    logic [DATA_WD-1:0] us, rd_val;
    logic [7:0]         fifo [8];
    logic [2:0]         wp, rp;
    logic [3:0]         cnt;
    always_comb begin
        a = data_sram.addr & ~ADDR_WD'(7);
        ram_off = a - RAM_BASE;
        ram_hit = a >= RAM_BASE && ram_off < RAM_BYTES;
        idx = ram_off[AW+2:3];
        uart_hit = a == UART_ADDR;
        wr = data_sram.en && |data_sram.wen;
        rd = data_sram.en && !(|data_sram.wen);
        uart_tx_valid = cnt != 4'd0;
        uart_tx_data = fifo[rp];
        pop = uart_tx_valid && uart_tx_ready;
        push_req = wr && uart_hit && data_sram.wen[0];
        push = push_req && (cnt != 4'd8 || pop);
        rd_val = ram_hit ? mem[idx] : uart_hit ? DATA_WD'(cnt) : rtc_hit ? us : '0;
    end
    always_ff @(posedge clk)
        if (reset && wr && ram_hit)
            for (int i = 0; i < WEN_WD; i++)
                if (data_sram.wen[i]) mem[idx][i*8 +: 8] <= data_sram.wdata[i*8 +: 8];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data_sram.rdata <= '0;
            bad_access <= 1'b0;
        end else begin
            if (rd) data_sram.rdata <= rd_val;
            if (data_sram.en && !(ram_hit || uart_hit || rtc_hit)) bad_access <= 1'b1;
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fifo <= '{default: '0};
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            uart_ovf_cnt <= '0;
        end else begin
            if (push) begin
                fifo[wp] <= data_sram.wdata[7:0];
                wp <= wp + 3'd1;
            end
            if (pop) rp <= rp + 3'd1;
            cnt <= cnt + 4'(push) - 4'(pop);
            if (push_req && !push && uart_ovf_cnt != 8'hff) uart_ovf_cnt <= uart_ovf_cnt + 8'd1;
        end
`ifdef YSYX_22041752_RTC_EN
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre;
    logic          clr, wrap;
    assign rtc_hit = a == RTC_ADDR;
    assign clr = wr && rtc_hit;
    assign wrap = pre == PW'(TICK_DIV - 1);
    // a software clear outranks a prescaler wrap landing on the same edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pre <= '0;
            us <= '0;
        end else if (clr) begin
            pre <= '0;
            us <= '0;
        end else if (wrap) begin
            pre <= '0;
            us <= us + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
`else
    logic unused_rtc;
    assign rtc_hit = 1'b0;
    assign us = '0;
    assign unused_rtc = ^{RTC_ADDR, TICK_DIV};
`endif
endmodule

// File: tb/tb_ysyx_22041752_data_sram_resp.sv
// tb_ysyx_22041752_data_sram_resp: scoreboard bench for RAM, UART FIFO, RTC and reset behaviour
module tb_ysyx_22041752_data_sram_resp;
    localparam logic [63:0] RAM     = 64'h8000_0000;
    localparam logic [63:0] RAM_END = 64'h8000_0200;
    localparam logic [63:0] UART    = 64'ha000_03f8;
    localparam logic [63:0] RTC     = 64'ha000_0048;
    localparam logic [63:0] MASKED  = 64'h1122_3344_BBBB_BBBB;
    localparam logic [63:0] LASTW   = 64'hDEAD_BEEF_CAFE_F00D;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic uart_tx_ready = 1'b0;
    logic [7:0] uart_tx_data, uart_ovf_cnt;
    logic uart_tx_valid, bad_access;
    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] rd_q[$];
    logic [7:0] tx_q[$];
    ysyx_22041752_data_sram_resp_if s ();
    ysyx_22041752_data_sram_resp #(.RAM_DEPTH(64), .TICK_DIV(4)) dut (
        .clk(clk),
        .reset(reset),
        .data_sram(s),
        .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_ovf_cnt(uart_ovf_cnt),
        .bad_access(bad_access)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic req(input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
        s.en = 1'b1;
        s.wen = w;
        s.addr = a;
        s.wdata = d;
        @(negedge clk);
        s.en = 1'b0;
        s.wen = '0;
    endtask
    task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] exp);
        rd_q.push_back(exp);
        req(8'h00, a, '0);
        chk(tag, s.rdata, rd_q.pop_front());
    endtask
    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) tx_q.push_back(b);
        req(8'h01, UART, 64'(b));
    endtask
    task automatic drain(input string tag, input int n);
        uart_tx_ready = 1'b1;
        repeat (n) @(negedge clk);
        uart_tx_ready = 1'b0;
        chk({tag, "_valid"}, 64'(uart_tx_valid), '0);
        chk({tag, "_left"}, 64'(tx_q.size()), '0);
    endtask
    always @(negedge clk) begin
        #1;
        if (reset && uart_tx_valid && uart_tx_ready) begin
            chk("tx_expected", 64'(tx_q.size() != 0), 64'd1);
            if (tx_q.size() != 0) chk("tx_byte", 64'(uart_tx_data), 64'(tx_q.pop_front()));
        end
    end
    initial begin
        s.en = 1'b0;
        s.wen = '0;
        s.addr = '0;
        s.wdata = '0;
        @(negedge clk);
        req(8'h01, UART, 64'h99);
        req(8'h00, 64'h1000, '0);
        chk("rst_rdata", s.rdata, '0);
        chk("rst_valid", 64'(uart_tx_valid), '0);
        chk("rst_txdata", 64'(uart_tx_data), '0);
        chk("rst_ovf", 64'(uart_ovf_cnt), '0);
        chk("rst_bad", 64'(bad_access), '0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ignored_valid", 64'(uart_tx_valid), '0);
        chk("rst_req_ignored_bad", 64'(bad_access), '0);
        req(8'hFF, RAM + 16, 64'h1122_3344_5566_7788);
        req(8'h0F, RAM + 16, 64'hAAAA_AAAA_BBBB_BBBB);
        rd("ram_mask", RAM + 16, MASKED);
        rd("ram_lowbits", RAM + 23, MASKED);
        req(8'hFF, RAM_END - 8, LASTW);
        rd("ram_last", RAM_END - 8, LASTW);
        req(8'hFF, RAM + 24, '0);
        repeat (2) @(negedge clk);
        chk("rdata_hold", s.rdata, LASTW);
        for (int i = 0; i < 10; i++) push_byte(8'h41 + 8'(i), i < 8);
        req(8'h02, UART, 64'h77);
        rd("uart_cnt_full", UART, 64'd8);
        chk("ovf_two", 64'(uart_ovf_cnt), 64'd2);
        drain("drain1", 8);
        rd("uart_cnt_empty", UART, '0);
        for (int i = 0; i < 8; i++) push_byte(8'h60 + 8'(i), 1'b1);
        uart_tx_ready = 1'b1;
        push_byte(8'h5A, 1'b1);
        uart_tx_ready = 1'b0;
        rd("uart_cnt_pushpop", UART, 64'd8);
        chk("ovf_pushpop", 64'(uart_ovf_cnt), 64'd2);
        drain("drain2", 8);
        push_byte(8'h31, 1'b1);
        uart_tx_ready = 1'b1;
        push_byte(8'h32, 1'b1);
        uart_tx_ready = 1'b0;
        rd("uart_cnt_one", UART, 64'd1);
        chk("head_advance", 64'(uart_tx_data), 64'h32);
        drain("drain3", 1);
        chk("bad_clear", 64'(bad_access), '0);
        rd("unmapped_rd", 64'h1000, '0);
        chk("bad_set", 64'(bad_access), 64'd1);
        req(8'hFF, 64'h2000, 64'h123);
        rd("ram_after_bad", RAM + 16, MASKED);
        chk("bad_sticky", 64'(bad_access), 64'd1);
        rd("ram_end_unmapped", RAM_END, '0);
        rd("ram_before_rtc", RAM + 16, MASKED);
`ifdef YSYX_22041752_RTC_EN
        req(8'hFF, RTC, '0);
        repeat (40) @(negedge clk);
        rd("rtc_ten", RTC, 64'd10);
        repeat (2) @(negedge clk);
        req(8'h01, RTC, '0);
        repeat (2) @(negedge clk);
        rd("rtc_clear_wins", RTC, '0);
        rd("rtc_still_zero", RTC, '0);
        @(negedge clk);
        rd("rtc_one", RTC, 64'd1);
`else
        rd("rtc_unmapped", RTC, '0);
        chk("rtc_bad", 64'(bad_access), 64'd1);
`endif
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i), 1'b1);
        uart_tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 64'(uart_tx_valid), '0);
        chk("async_txdata", 64'(uart_tx_data), '0);
        chk("async_rdata", s.rdata, '0);
        chk("async_ovf", 64'(uart_ovf_cnt), '0);
        chk("async_bad", 64'(bad_access), '0);
        tx_q.delete();
        uart_tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd("post_rst_cnt", UART, '0);
        rd("post_rst_ram", RAM + 16, MASKED);
        rd("post_rst_last", RAM_END - 8, LASTW);
        chk("post_rst_bad", 64'(bad_access), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
